// File: rtl/tt_tile_out_capture.sv
// Capture stage for a microtile's 8-bit output: synchronizes the bus, detects value
// changes and queues {value, timestamp} entries in a first-word fall-through FIFO.
module tt_tile_out_capture #(
  parameter int DEPTH       = 4,
  parameter int STAMP_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   tile_out,
  input  logic                         enable,
  input  logic                         rd_ready,
  input  logic                         clear_ovf,
  output logic                         rd_valid,
  output logic [7:0]                   rd_data,
  output logic [STAMP_W-1:0]           rd_stamp,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0]      PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]      CNT_FULL  = CW'(DEPTH);
  localparam logic [STAMP_W-1:0] STAMP_ONE = STAMP_W'(1);

  logic [7:0]         sync_p0 [SYNC_STAGES];
  logic [7:0]         s;
  logic [7:0]         prev_p1;
  logic [STAMP_W-1:0] stamp;

  logic [7:0]         mem_data  [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  logic evt, full, pop, push, drop;

  // Stage p0: synchronizer chain on the asynchronous tile bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '0;
    end else begin
      sync_p0[0] <= tile_out;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

  assign s = sync_p0[SYNC_STAGES-1];

  // Stage p1: change detection against the previous sample and the free-running stamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p1 <= '0;
      stamp   <= '0;
    end else begin
      prev_p1 <= s;
      stamp   <= stamp + STAMP_ONE;
    end
  end

  assign evt  = enable && (s != prev_p1);
  assign full = (count == CNT_FULL);
  assign pop  = rd_valid && rd_ready;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  // Stage p2: FIFO storage; contents are only observable through the valid-gated head
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= s;
      mem_stamp[wr_ptr] <= stamp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem_data[rd_ptr]  : '0;
  assign rd_stamp = rd_valid ? mem_stamp[rd_ptr] : '0;

endmodule

// File: tb/tb_tt_tile_out_capture.sv
// Directed bench for tt_tile_out_capture: a scoreboard queue holds the expected
// {value, stamp} entries and each pop observed on the read port is compared in order.
module tb_tt_tile_out_capture;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    tile_out;
  logic          enable;
  logic          rd_ready;
  logic          clear_ovf;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [SW-1:0] rd_stamp;
  logic [2:0]    count;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int tb_cnt   = 0;
  logic [7+SW:0] sb [$];

  always #5 clk = ~clk;

  tt_tile_out_capture #(.DEPTH(4), .STAMP_W(SW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tile_out(tile_out), .enable(enable),
    .rd_ready(rd_ready), .clear_ovf(clear_ovf), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_stamp(rd_stamp), .count(count), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare any pop at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [7+SW:0] e;
    @(negedge clk);
    if (rd_valid === 1'b1 && rd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL pop_unexpected: observed data=0x%0h stamp=0x%0h expected no entry", rd_data, rd_stamp);
      end else begin
        e = sb.pop_front();
        chk("pop_data",  32'(rd_data),  32'(e[7+SW:SW]));
        chk("pop_stamp", 32'(rd_stamp), 32'(e[SW-1:0]));
      end
    end
    @(posedge clk);
    tb_cnt++;
    #1;
  endtask

  // Event is evaluated two cycles after the drive, when the counter reads tb_cnt+2.
  task automatic drive(input logic [7:0] v, input bit keep);
    tile_out = v;
    if (keep) sb.push_back({v, SW'(tb_cnt + 2)});
  endtask

  initial begin
    rst_n = 1'b0; tile_out = 8'h00; enable = 1'b1; rd_ready = 1'b0; clear_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    32'(rd_valid), 32'd0);
    chk("rst_data",     32'(rd_data),  32'd0);
    chk("rst_stamp",    32'(rd_stamp), 32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n  = 1'b1;
    tb_cnt = 0;

    // single change and latency
    while (tb_cnt != 10) tick();
    drive(8'h5A, 1'b1);
    tick(); tick();
    chk("lat_early_valid", 32'(rd_valid), 32'd0);
    tick();
    chk("single_valid", 32'(rd_valid), 32'd1);
    chk("single_data",  32'(rd_data),  32'h5A);
    chk("single_stamp", 32'(rd_stamp), 32'd12);
    chk("single_count", 32'(count),    32'd1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("single_drained", 32'(count), 32'd0);

    // no re-flag of a held value
    repeat (20) tick();
    chk("noreflag_count", 32'(count),    32'd0);
    chk("noreflag_valid", 32'(rd_valid), 32'd0);

    // burst overflow
    for (int v = 1; v <= 6; v++) begin
      drive(8'(v), v <= 4);
      tick();
    end
    repeat (3) tick();
    chk("burst_count", 32'(count),    32'd4);
    chk("burst_ovf",   32'(overflow), 32'd1);
    chk("burst_head",  32'(rd_data),  32'h01);
    rd_ready = 1'b1; repeat (4) tick(); rd_ready = 1'b0;
    chk("burst_valid_drop", 32'(rd_valid), 32'd0);
    chk("burst_count_zero", 32'(count),    32'd0);

    // full with simultaneous push and pop
    for (int v = 8'h11; v <= 8'h14; v++) begin
      drive(8'(v), 1'b1);
      tick();
    end
    repeat (3) tick();
    chk("full_count", 32'(count), 32'd4);
    drive(8'h77, 1'b1);
    tick(); tick();
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("pushpop_count", 32'(count),    32'd4);
    chk("pushpop_ovf",   32'(overflow), 32'd1);
    rd_ready = 1'b1; repeat (4) tick(); rd_ready = 1'b0;
    chk("pushpop_drained", 32'(count),      32'd0);
    chk("pushpop_sb",      32'(sb.size()),  32'd0);

    // enable gating
    enable = 1'b0;
    drive(8'h10, 1'b0); repeat (4) tick();
    drive(8'h20, 1'b0); repeat (4) tick();
    enable = 1'b1;
    repeat (5) tick();
    chk("gate_none", 32'(count), 32'd0);
    drive(8'h30, 1'b1);
    repeat (3) tick();
    chk("gate_one_count", 32'(count),   32'd1);
    chk("gate_one_data",  32'(rd_data), 32'h30);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("gate_drained", 32'(count), 32'd0);

    // stamp wrap
    while ((tb_cnt % 16) != 13) tick();
    drive(8'h41, 1'b1);
    tick(); tick();
    drive(8'h42, 1'b1);
    tick();
    chk("wrap_stamp15", 32'(rd_stamp), 32'd15);
    chk("wrap_data41",  32'(rd_data),  32'h41);
    tick(); tick();
    chk("wrap_count", 32'(count), 32'd2);
    rd_ready = 1'b1; tick();
    chk("wrap_stamp1", 32'(rd_stamp), 32'd1);
    tick(); rd_ready = 1'b0;
    chk("wrap_drained", 32'(count), 32'd0);

    // overflow clear, then clear colliding with a new drop
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int v = 8'h51; v <= 8'h55; v++) begin
      drive(8'(v), v != 8'h55);
      tick();
    end
    tick();
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("ovf_clear_alone", 32'(overflow), 32'd0);
    chk("ovf_count",       32'(count),    32'd4);
    rd_ready = 1'b1; repeat (4) tick(); rd_ready = 1'b0;
    chk("empty_valid", 32'(rd_valid), 32'd0);
    chk("empty_data",  32'(rd_data),  32'd0);
    chk("empty_stamp", 32'(rd_stamp), 32'd0);
    chk("empty_count", 32'(count),    32'd0);

    // reset mid-operation discards contents immediately
    drive(8'h66, 1'b0);
    repeat (3) tick();
    chk("midrst_pre_count", 32'(count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count),    32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_data",  32'(rd_data),  32'd0);
    chk("sb_drained",   32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
